// File: rtl/controle_prioridade_pkg.sv
// controle_prioridade_pkg: priority codes and mode state encoding shared by the selector front end
package controle_prioridade_pkg;
  localparam logic [1:0] P_OFF = 2'b00;
  localparam logic [1:0] P_A   = 2'b10;
  localparam logic [1:0] P_B   = 2'b01;
  localparam logic [1:0] P_AB  = 2'b11;
  // state encoding equals the P code so the output is the state register itself
  typedef enum logic [1:0] {
    S_OFF = P_OFF,
    S_A   = P_A,
    S_B   = P_B,
    S_AB  = P_AB
  } state_t;
  function automatic state_t next_mode(state_t s);
    return s == S_OFF ? S_A : s == S_A ? S_B : s == S_B ? S_AB : S_OFF;
  endfunction
endpackage

// File: rtl/controle_prioridade_debouncer_botao.sv
// debouncer_botao: 2-flop synchroniser, stable-level debounce and one-cycle press pulse
module debouncer_botao #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d, prev_q;
  logic             btn_s;
  assign btn_s = sync_q[1];
  // the level flips on the edge the run of differing samples would reach DEB_CYCLES
  always_comb begin
    cnt_d    = (btn_s == stable_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    stable_d = (btn_s != stable_q && cnt_q == CNT_LAST) ? btn_s : stable_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end
  assign press_o = stable_q & ~prev_q;
endmodule

// File: rtl/controle_prioridade.sv
// controle_prioridade: debounced mode/lock buttons driving the registered priority code P
module controle_prioridade
  import controle_prioridade_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTN_MODE,
  input  logic       BTN_LOCK,
  output logic [1:0] P,
  output logic       LOCKED,
  output logic       P_CHG
);
  state_t state_q, state_d;
  logic   locked_q, locked_d, chg_q, chg_d;
  logic   mode_ev, lock_ev;
  debouncer_botao #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_mode (
    .clk(clk), .reset(reset), .btn_i(BTN_MODE), .press_o(mode_ev)
  );
  debouncer_botao #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_lock (
    .clk(clk), .reset(reset), .btn_i(BTN_LOCK), .press_o(lock_ev)
  );
  // mode decision sees the pre-toggle lock so simultaneous presses resolve deterministically
  always_comb begin
    chg_d    = mode_ev & ~locked_q;
    state_d  = chg_d ? next_mode(state_q) : state_q;
    locked_d = locked_q ^ lock_ev;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_OFF;
      locked_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      chg_q    <= chg_d;
    end
  end
  assign P      = state_q;
  assign LOCKED = locked_q;
  assign P_CHG  = chg_q;
endmodule

// File: tb/tb_controle_prioridade.sv
// tb_controle_prioridade: random and directed button stimulus checked against a sample-window model
module tb_controle_prioridade;
  localparam int DEB = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_lock = 1'b0;
  logic [1:0] p;
  logic       locked, p_chg;
  int         n_chk = 0;
  int         n_fail = 0;
  controle_prioridade #(.DEB_CYCLES(DEB), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .BTN_MODE(btn_mode), .BTN_LOCK(btn_lock),
    .P(p), .LOCKED(locked), .P_CHG(p_chg)
  );
  always #5 clk = ~clk;
  // model: raw-sample history per button, debounced levels, mode index into the code table
  bit         h_m [DEB+2];
  bit         h_l [DEB+2];
  bit         lvl_m, lvl_l, rose_m, rose_l, m_locked, m_chg;
  int         idx;
  logic [1:0] codes [4];
  int         pulses;
  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < DEB + 2; j++) begin
      h_m[j] = 1'b0;
      h_l[j] = 1'b0;
    end
    {lvl_m, lvl_l, rose_m, rose_l, m_locked, m_chg} = '0;
    idx = 0;
  endtask
  // a level flips once the DEB most recent synchronised samples all disagree with it
  task automatic model_edge();
    bit all_m, all_l;
    m_chg = 1'b0;
    if (rose_m && !m_locked) begin
      idx   = (idx + 1) % 4;
      m_chg = 1'b1;
    end
    if (rose_l) m_locked = !m_locked;
    for (int j = DEB + 1; j > 0; j--) begin
      h_m[j] = h_m[j-1];
      h_l[j] = h_l[j-1];
    end
    h_m[0] = btn_mode;
    h_l[0] = btn_lock;
    all_m = 1'b1;
    all_l = 1'b1;
    for (int j = 2; j <= DEB + 1; j++) begin
      if (h_m[j] == lvl_m) all_m = 1'b0;
      if (h_l[j] == lvl_l) all_l = 1'b0;
    end
    rose_m = all_m && !lvl_m;
    rose_l = all_l && !lvl_l;
    if (all_m) lvl_m = !lvl_m;
    if (all_l) lvl_l = !lvl_l;
  endtask
  task automatic tick(bit m, bit l);
    btn_mode = m;
    btn_lock = l;
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check("p", 8'(p), 8'(codes[idx]));
    check("locked", 8'(locked), 8'(m_locked));
    check("p_chg", 8'(p_chg), 8'(m_chg));
    if (p_chg) pulses++;
  endtask
  task automatic press(bit m, bit l);
    repeat (10) tick(m, l);
    repeat (10) tick(1'b0, 1'b0);
  endtask
  task automatic pulse_reset(int cyc);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_p", 8'(p), 8'h00);
    check("rst_chg", 8'(p_chg), 8'h00);
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
  endtask
  initial begin
    int first, len;
    bit m, l;
    codes[0] = 2'b00;
    codes[1] = 2'b10;
    codes[2] = 2'b01;
    codes[3] = 2'b11;
    model_reset();
    pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    check("init_p", 8'(p), 8'h00);
    check("init_lock", 8'(locked), 8'h00);
    check("init_chg", 8'(p_chg), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 1'b0);
      if (p_chg && first == 0) first = i;
    end
    check("latency_edge", 8'(first), 8'(DEB + 3));
    check("held_pulses", 8'(pulses), 8'd1);
    check("held_p", 8'(p), 8'b10);
    repeat (10) tick(1'b0, 1'b0);
    pulse_reset(2);
    press(1'b1, 1'b0);
    check("seq1", 8'(p), 8'b10);
    press(1'b1, 1'b0);
    check("seq2", 8'(p), 8'b01);
    press(1'b1, 1'b0);
    check("seq3", 8'(p), 8'b11);
    press(1'b1, 1'b0);
    check("seq4", 8'(p), 8'b00);
    check("seq_pulses", 8'(pulses), 8'd4);
    pulses = 0;
    for (int g = 1; g <= 3; g++) begin
      repeat (5) begin
        repeat (g) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
      end
    end
    check("glitch_p", 8'(p), 8'b00);
    check("glitch_pulses", 8'(pulses), 8'd0);
    press(1'b0, 1'b1);
    check("lock_on", 8'(locked), 8'd1);
    press(1'b1, 1'b0);
    check("locked_hold", 8'(p), 8'b00);
    check("locked_nochg", 8'(pulses), 8'd0);
    press(1'b0, 1'b1);
    check("lock_off", 8'(locked), 8'd0);
    press(1'b1, 1'b0);
    check("unlock_adv", 8'(p), 8'b10);
    press(1'b1, 1'b1);
    check("both_p", 8'(p), 8'b01);
    check("both_lock", 8'(locked), 8'd1);
    press(1'b1, 1'b1);
    check("both_locked_p", 8'(p), 8'b01);
    check("both_locked_lock", 8'(locked), 8'd0);
    pulse_reset(2);
    press(1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    pulse_reset(2);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 1'b0);
      if (p_chg && first == 0) first = i;
    end
    check("rst_refire_edge", 8'(first), 8'(DEB + 3));
    check("rst_refire_p", 8'(p), 8'b10);
    for (int r = 0; r < 150; r++) begin
      m = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 9);
      repeat (len) tick(m, l);
      if ($urandom_range(0, 40) == 0) pulse_reset($urandom_range(1, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
